// File: rtl/aes_ctrl_pkg.sv
// Shared types for the inv_aes job scheduler.
//   aes_block_t     : one 128-bit AES block (data or key)
//   sched_state_t   : scheduler FSM states
//   INV_AES_LATENCY : cycles from core start to core result valid
package aes_ctrl_pkg;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

    localparam int INV_AES_LATENCY = 11;

endpackage

// File: rtl/inv_aes_job_sched_rr_arbiter.sv
// Round-robin priority rotate, purely combinational.
// Ports:
//   req     : request vector
//   ptr     : highest-priority index this cycle
//   en      : grant enable; no grant when low
//   gnt     : one-hot grant (or zero)
//   gnt_idx : encoded index of gnt (0 when no grant)
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    int idx;

    // Walk from the farthest candidate back to ptr so the nearest
    // requester at or after ptr overwrites any earlier pick.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        if (en) begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = (int'(ptr) + k) % N;
                if (req[idx]) begin
                    gnt      = '0;
                    gnt[idx] = 1'b1;
                    gnt_idx  = IW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/inv_aes_job_sched.sv
// Shares one iterative inv_aes decryption core among NUM_REQ requesters.
// Round-robin grant, one job in flight, single-entry tagged response register.
// Optional feature macro: AES_SCHED_TIMEOUT_EN (watchdog on the core result).
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   req_valid/ready/data/key : per-requester job handshake (128-bit slices)
//   core_start/data/key      : one-cycle start pulse and operands to the core
//   core_res_valid/data      : core result strobe and plaintext
//   resp_valid/ready/id/data : tagged response with backpressure
//   busy                     : job in flight or response pending
//   timeout_err              : sticky watchdog flag (0 without the macro)
module inv_aes_job_sched
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_data,
    input  logic [NUM_REQ*128-1:0] req_key,
    output logic                   core_start,
    output logic [127:0]           core_data,
    output logic [127:0]           core_key,
    input  logic                   core_res_valid,
    input  logic [127:0]           core_res_data,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [127:0]           resp_data,
    output logic                   busy,
    output logic                   timeout_err
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_cfg
        $error("inv_aes_job_sched: unsupported NUM_REQ/TIMEOUT_CYC");
    end

    sched_state_t        state_q;
    logic [ID_W-1:0]     ptr_q, id_q, ptr_d;
    aes_block_t          data_q, key_q, resp_data_q;
    logic                resp_valid_q;
    logic [ID_W-1:0]     resp_id_q;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                arb_en;

    // A draining response frees the register this cycle, so a grant may
    // overlap the handshake.
    assign arb_en = (state_q == IDLE) && (!resp_valid_q || resp_ready);

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Next round-robin start: one past the requester just served.
    assign ptr_d = (int'(id_q) == NUM_REQ - 1) ? '0 : id_q + 1'b1;

`ifdef AES_SCHED_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       timeout_q;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            data_q       <= '0;
            key_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            if (resp_valid_q && resp_ready) resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        data_q  <= req_data[int'(gnt_idx)*128 +: 128];
                        key_q   <= req_key[int'(gnt_idx)*128 +: 128];
                        id_q    <= gnt_idx;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
`ifdef AES_SCHED_TIMEOUT_EN
                    // Count includes the start cycle itself.
                    cnt_q   <= 8'd1;
`endif
                end
                WAIT: begin
                    // resp_valid_q is always 0 here: no grant while it is set.
                    if (core_res_valid) begin
                        resp_data_q  <= core_res_data;
                        resp_id_q    <= id_q;
                        resp_valid_q <= 1'b1;
                        ptr_q        <= ptr_d;
                        state_q      <= IDLE;
                    end
`ifdef AES_SCHED_TIMEOUT_EN
                    else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                        timeout_q <= 1'b1;
                        ptr_q     <= ptr_d;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = gnt;
    assign core_start = (state_q == ISSUE);
    assign core_data  = data_q;
    assign core_key   = key_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign busy       = (state_q != IDLE) || resp_valid_q;

endmodule

// File: tb/tb_inv_aes_job_sched.sv
module tb_inv_aes_job_sched;
    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int LAT = 11;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid, req_ready;
    logic [N*128-1:0] req_data, req_key;
    logic             core_start;
    logic [127:0]     core_data, core_key;
    logic             core_res_valid;
    logic [127:0]     core_res_data;
    logic             resp_valid, resp_ready;
    logic [IW-1:0]    resp_id;
    logic [127:0]     resp_data;
    logic             busy, timeout_err;

    always #5 clk = ~clk;

    inv_aes_job_sched #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_key(req_key),
        .core_start(core_start), .core_data(core_data), .core_key(core_key),
        .core_res_valid(core_res_valid), .core_res_data(core_res_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event seen/missed at cycle %0d, required otherwise", name, cyc);
    endtask

    // Stand-in for the decryption core: the FIPS-197 vector decrypts
    // properly; anything else maps through a fixed reversible mix.
    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
        if (d == FIPS_CT && k == FIPS_K) return FIPS_PT;
        return d ^ {k[63:0], k[127:64]} ^ 128'h5a;
    endfunction

    // ---------------- stub core (shares reset) ----------------
    int           core_cnt  = 0;
    logic [127:0] core_hold = '0;
    bit           stub_dead = 0;
    bit           spurious  = 0;
    initial begin
        core_res_valid = 1'b0;
        core_res_data  = '0;
        forever begin
            @(posedge clk); #2;
            core_res_valid = 1'b0;
            if (reset) core_cnt = 0;
            else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_res_valid = 1'b1;
                    core_res_data  = core_hold;
                end
            end
            if (spurious) begin
                core_res_valid = 1'b1;
                core_res_data  = 128'hdead_beef;
                spurious       = 0;
            end
            if (core_start && !reset) begin
                if (core_cnt != 0) fail("core_start_while_busy");
                core_cnt  = stub_dead ? 0 : LAT;
                core_hold = core_fn(core_data, core_key);
            end
        end
    end

    // ---------------- requester driver ----------------
    int       mode = 0;          // 0 manual, 1 all continuous, 2 random
    bit [N-1:0] granted_flag = '0;

    task automatic new_job(input int i);
        req_data[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        req_key[i*128 +: 128]  = {$urandom, $urandom, $urandom, $urandom};
        req_valid[i] = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (granted_flag[i]) begin
                    if (mode == 1 || (mode == 2 && $urandom_range(1, 0) == 1)) new_job(i);
                    else req_valid[i] = 1'b0;
                end else if (mode == 2 && !req_valid[i] && $urandom_range(3, 0) == 0) new_job(i);
                else if (mode == 2 && req_valid[i] && $urandom_range(15, 0) == 0) req_valid[i] = 1'b0;
            end
            granted_flag = '0;
            if (mode == 2) resp_ready = ($urandom_range(2, 0) != 0);
        end
    end

    // ---------------- reference model + scoreboard monitor ----------------
    typedef struct { logic [IW-1:0] id; logic [127:0] d; int acc; } exp_t;
    exp_t         q[$];
    int           gnt_log[$];
    int           ptr_m = 0, start_due = -1, start_cyc = 0;
    bit           busy_m = 0, holding = 0, te_m = 0;
    logic [IW-1:0] h_id;
    logic [127:0] h_d, exp_cd, exp_ck, last_data;

    initial begin
        exp_t         e;
        logic [N-1:0] exp_g;
        int           g;
        forever begin
            @(negedge clk);
            if (reset) begin
                ptr_m = 0; busy_m = 0; holding = 0; start_due = -1; te_m = 0;
                q.delete();
                continue;
            end
            // response side
            if (resp_valid) begin
                if (!holding) begin
                    if (q.size() == 0) fail("resp_unexpected");
                    else begin
                        e = q.pop_front();
                        chk("resp_id", resp_id, e.id);
                        chk("resp_data", resp_data, e.d);
                        chk("resp_latency", cyc - e.acc, 13);
                        busy_m = 0;
                    end
                    holding = 1; h_id = resp_id; h_d = resp_data; last_data = resp_data;
                end else begin
                    chk("resp_id_stable", resp_id, h_id);
                    chk("resp_data_stable", resp_data, h_d);
                end
                if (resp_ready) holding = 0;
            end else if (holding) begin
                fail("resp_dropped_without_handshake");
                holding = 0;
            end
`ifdef AES_SCHED_TIMEOUT_EN
            if (busy_m && stub_dead && cyc == start_cyc + 16) begin
                te_m = 1; busy_m = 0;
                if (q.size() != 0) void'(q.pop_front());
            end
`endif
            chk("timeout_err", timeout_err, te_m);
            chk("busy", busy, busy_m || resp_valid);
            // core issue
            chk("core_start", core_start, cyc == start_due);
            if (core_start && cyc == start_due) begin
                chk("core_data", core_data, exp_cd);
                chk("core_key", core_key, exp_ck);
                start_cyc = cyc;
            end
            // arbitration
            exp_g = '0;
            g     = -1;
            if (!busy_m && (!resp_valid || resp_ready)) begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
                if (g >= 0) exp_g[g] = 1'b1;
            end
            chk("req_ready", req_ready, exp_g);
            granted_flag = granted_flag | req_ready;
            if (g >= 0) begin
                e.id  = IW'(g);
                e.d   = core_fn(req_data[g*128 +: 128], req_key[g*128 +: 128]);
                e.acc = cyc;
                q.push_back(e);
                exp_cd = req_data[g*128 +: 128];
                exp_ck = req_key[g*128 +: 128];
                ptr_m = (g + 1) % N;
                busy_m = 1;
                start_due = cyc + 1;
                gnt_log.push_back(g);
            end
        end
    end

    // ---------------- main sequence ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #3; end
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((busy || req_valid != '0 || q.size() != 0) && n < max) begin tick(1); n++; end
        if (n >= max) fail("wait_idle_bound");
    endtask

    task automatic pulse_reset();
        reset = 1'b1; req_valid = '0; tick(2); reset = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; req_valid = '0; req_data = '0; req_key = '0; resp_ready = 1'b1;
        tick(3);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_data", resp_data, 0);
        reset = 1'b0;

        // 1) FIPS-197 vector through requester 0
        req_data[127:0] = FIPS_CT; req_key[127:0] = FIPS_K; req_valid[0] = 1'b1;
        wait_idle(60);
        chk("fips_plaintext", last_data, FIPS_PT);

        // 2) all requesters continuously valid from pointer 0
        pulse_reset();
        gnt_log.delete();
        for (int i = 0; i < N; i++) new_job(i);
        mode = 1;
        n = 0;
        while (gnt_log.size() < 5 && n < 200) begin tick(1); n++; end
        mode = 0;
        if (gnt_log.size() < 5) fail("rr_grant_bound");
        else for (int i = 0; i < 5; i++) chk("rr_order", gnt_log[i], i % N);
        wait_idle(200);

        // 3) backpressure holds the response and blocks new grants
        pulse_reset();
        resp_ready = 1'b0;
        new_job(0); new_job(1);
        n = 0;
        while (!resp_valid && n < 40) begin tick(1); n++; end
        if (!resp_valid) fail("bp_resp_bound");
        tick(20);
        chk("bp_no_start", core_start, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        chk("grant_on_drain", req_ready, 4'b0010);
        tick(1);
        wait_idle(60);

        // 5) spurious core result while idle
        spurious = 1;
        tick(4);
        chk("spurious_resp_valid", resp_valid, 0);

        // 4) reset in the 5th WAIT cycle, then a fresh job
        new_job(3);
        n = 0;
        while (!core_start && n < 20) begin tick(1); n++; end
        if (!core_start) fail("start_bound");
        tick(5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_core_start", core_start, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        new_job(2);
        wait_idle(60);

        // random traffic with random backpressure
        mode = 2;
        tick(500);
        mode = 0;
        resp_ready = 1'b1;
        wait_idle(400);

`ifdef AES_SCHED_TIMEOUT_EN
        // 6) core never answers: watchdog fires and the next requester runs
        stub_dead = 1;
        new_job(0); new_job(1);
        wait_idle(120);
        stub_dead = 0;
        chk("timeout_sticky", timeout_err, 1);
`endif

        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_time_bound: simulation did not end");
        $fatal(1);
    end
endmodule
